// File: rtl/c5_burst_decrementer_if.sv
// Request/response bundle for the descending-address burst generator.
// The master modport faces the requester/consumer side; slave is the generator.
interface c5_burst_decrementer_if #(
  parameter int unsigned COUNT_W = 8
) ();
  logic               I_start;
  logic [31:2]        I_addr;
  logic [COUNT_W-1:0] I_count;
  logic               I_abort;
  logic               I_ready;
  logic               O_valid;
  logic [31:2]        O_addr;
  logic               O_last;
  logic               O_busy;
  logic               O_done;
  logic               O_wrap;

  modport master (
    output I_start, I_addr, I_count, I_abort, I_ready,
    input  O_valid, O_addr, O_last, O_busy, O_done, O_wrap
  );

  modport slave (
    input  I_start, I_addr, I_count, I_abort, I_ready,
    output O_valid, O_addr, O_last, O_busy, O_done, O_wrap
  );
endinterface

// File: rtl/c5_burst_decrementer.sv
// Burst address generator: walks word addresses downward from a start address,
// one beat per accepted handshake, with abort, zero-length bursts and wrap flag.
module c5_burst_decrementer #(
  parameter int unsigned COUNT_W = 8
) (
  input  logic                    I_clk,
  input  logic                    I_rst_n,
  c5_burst_decrementer_if.slave   bus
);

  localparam int unsigned ADDR_W = 30;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  addr_q,  addr_d;
  logic [COUNT_W-1:0] cnt_q,   cnt_d;
  logic               valid_q, valid_d;
  logic               last_q,  last_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic               wrap_q,  wrap_d;

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wrap_d  = wrap_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.I_start) begin
          wrap_d = 1'b0;
          busy_d = 1'b1;
          if (bus.I_count != '0) begin
            state_d = ST_RUN;
            addr_d  = bus.I_addr;
            cnt_d   = bus.I_count;
            valid_d = 1'b1;
            last_d  = (bus.I_count == COUNT_W'(1));
          end else begin
            // Zero-length burst spends one silent cycle in DONE before pulsing
            state_d = ST_DONE;
          end
        end
      end

      ST_RUN: begin
        if (bus.I_abort) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (bus.I_ready) begin
          if (last_q) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q - ADDR_W'(1);
            cnt_d  = cnt_q - COUNT_W'(1);
            last_d = (cnt_q == COUNT_W'(2));
            if (addr_q == '0) begin
              wrap_d = 1'b1;
            end
          end
        end
      end

      ST_DONE: begin
        // Leave once the completion pulse has been shown
        if (done_q) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          done_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.O_valid = valid_q;
  assign bus.O_addr  = addr_q;
  assign bus.O_last  = last_q;
  assign bus.O_busy  = busy_q;
  assign bus.O_done  = done_q;
  assign bus.O_wrap  = wrap_q;

endmodule

// File: tb/tb_c5_burst_decrementer.sv
// Directed bench for c5_burst_decrementer: inputs change and outputs are
// sampled on the falling clock edge, expected values are hand-computed.
module tb_c5_burst_decrementer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  c5_burst_decrementer_if #(.COUNT_W(8)) bus ();

  c5_burst_decrementer #(.COUNT_W(8)) dut (
    .I_clk   (clk),
    .I_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Compare every output; address only matters while a beat is shown
  task automatic expect_out(input string tag, input logic v, input logic [29:0] a,
                            input logic l, input logic b, input logic d, input logic w);
    chk({tag, ".valid"}, 32'(bus.O_valid), 32'(v));
    if (v) chk({tag, ".addr"}, 32'(bus.O_addr), 32'(a));
    chk({tag, ".last"}, 32'(bus.O_last), 32'(l));
    chk({tag, ".busy"}, 32'(bus.O_busy), 32'(b));
    chk({tag, ".done"}, 32'(bus.O_done), 32'(d));
    chk({tag, ".wrap"}, 32'(bus.O_wrap), 32'(w));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic start_burst(input logic [29:0] a, input logic [7:0] c);
    bus.I_start = 1'b1;
    bus.I_addr  = a;
    bus.I_count = c;
    step();
    bus.I_start = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n       = 1'b0;
    bus.I_start = 1'b0;
    bus.I_addr  = '0;
    bus.I_count = '0;
    bus.I_abort = 1'b0;
    bus.I_ready = 1'b0;
    #1;
    chk("rst.valid", 32'(bus.O_valid), 32'h0);
    chk("rst.addr",  32'(bus.O_addr),  32'h0);
    chk("rst.busy",  32'(bus.O_busy),  32'h0);
    chk("rst.wrap",  32'(bus.O_wrap),  32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Abort while idle does nothing
    bus.I_abort = 1'b1;
    step();
    bus.I_abort = 1'b0;
    expect_out("idle_abort", 1'b0, 30'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Basic 3-beat burst
    bus.I_ready = 1'b1;
    start_burst(30'h10, 8'd3);
    expect_out("b1.0", 1'b1, 30'h10, 1'b0, 1'b1, 1'b0, 1'b0);
    step(); expect_out("b1.1", 1'b1, 30'h0F, 1'b0, 1'b1, 1'b0, 1'b0);
    step(); expect_out("b1.2", 1'b1, 30'h0E, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); expect_out("b1.done", 1'b0, 30'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(); expect_out("b1.idle", 1'b0, 30'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Wrap below zero
    start_burst(30'h2, 8'd4);
    expect_out("w.0", 1'b1, 30'h2, 1'b0, 1'b1, 1'b0, 1'b0);
    step(); expect_out("w.1", 1'b1, 30'h1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(); expect_out("w.2", 1'b1, 30'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(); expect_out("w.3", 1'b1, 30'h3FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
    step(); expect_out("w.done", 1'b0, 30'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(); expect_out("w.idle", 1'b0, 30'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure: three stalled edges, start clears wrap
    bus.I_ready = 1'b0;
    start_burst(30'h21, 8'd2);
    expect_out("bp.0", 1'b1, 30'h21, 1'b0, 1'b1, 1'b0, 1'b0);
    step(); expect_out("bp.1", 1'b1, 30'h21, 1'b0, 1'b1, 1'b0, 1'b0);
    step(); expect_out("bp.2", 1'b1, 30'h21, 1'b0, 1'b1, 1'b0, 1'b0);
    step(); expect_out("bp.3", 1'b1, 30'h21, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.I_ready = 1'b1;
    step(); expect_out("bp.4", 1'b1, 30'h20, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); expect_out("bp.done", 1'b0, 30'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(); expect_out("bp.idle", 1'b0, 30'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Zero-length burst
    start_burst(30'h55, 8'd0);
    expect_out("z.0", 1'b0, 30'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(); expect_out("z.1", 1'b0, 30'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(); expect_out("z.idle", 1'b0, 30'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort on second beat; a start during RUN is ignored
    start_burst(30'h100, 8'd5);
    expect_out("ab.0", 1'b1, 30'h100, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.I_start = 1'b1;
    bus.I_addr  = 30'h777;
    bus.I_count = 8'd1;
    step();
    bus.I_start = 1'b0;
    expect_out("ab.1", 1'b1, 30'h0FF, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.I_abort = 1'b1;
    step();
    bus.I_abort = 1'b0;
    expect_out("ab.idle", 1'b0, 30'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); expect_out("ab.nodone", 1'b0, 30'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    start_burst(30'h50, 8'd1);
    expect_out("ab.new", 1'b1, 30'h50, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); expect_out("ab.newdone", 1'b0, 30'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();

    // Asynchronous reset mid-burst, checked before the next rising edge
    start_burst(30'h40, 8'd5);
    expect_out("rs.0", 1'b1, 30'h40, 1'b0, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rs.valid", 32'(bus.O_valid), 32'h0);
    chk("rs.addr",  32'(bus.O_addr),  32'h0);
    chk("rs.last",  32'(bus.O_last),  32'h0);
    chk("rs.busy",  32'(bus.O_busy),  32'h0);
    chk("rs.done",  32'(bus.O_done),  32'h0);
    chk("rs.wrap",  32'(bus.O_wrap),  32'h0);
    step();
    rst_n = 1'b1;
    step(); expect_out("rs.idle", 1'b0, 30'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    start_burst(30'h7, 8'd1);
    expect_out("rs.new", 1'b1, 30'h7, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); expect_out("rs.newdone", 1'b0, 30'h0, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
